key_press_latch: RTL and testbench

//  Front-end input stage for the xasted game core. It synchronises and debounces the
//  two active-low push buttons and converts each debounced press into a one-shot

---
 rtl/key_press_latch_if.sv | 21 ++
 rtl/key_press_latch.sv | 95 +++++++++
 tb/tb_key_press_latch.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_press_latch_if.sv
// Signal bundle between the push-button front end and the game core.
// Names follow the board-level pin and port names of the xasted core.
interface key_press_latch_if;
  logic [1:0] KEY;
  logic       clr_lost;
  logic       tick;
  logic       pressed_high;
  logic       pressed_low;
  logic [1:0] key_level;
  logic       press_lost;

  modport master (
    output KEY, clr_lost,
    input  tick, pressed_high, pressed_low, key_level, press_lost
  );

  modport slave (
    input  KEY, clr_lost,
    output tick, pressed_high, pressed_low, key_level, press_lost
  );
endinterface

// File: rtl/key_press_latch.sv
// Button front end: synchronise and debounce two active-low keys, turn presses into
// one-shot events held in a single-slot latch, and generate the game tick strobe.
module key_press_latch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int TICK_DIV_BIT    = 21
) (
  input  logic             MAX10_CLK1_50,
  input  logic             RST,
  key_press_latch_if.slave bus
);
  localparam int               DIV_W    = TICK_DIV_BIT + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // One-hot slot encoding: each output is a plain flop bit and both can never be set.
  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'b00,
    SLOT_HIGH  = 2'b01,
    SLOT_LOW   = 2'b10
  } slot_e;

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       key_level_q, key_level_d;
  logic [1:0]       press_q, press_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  slot_e            slot_q, slot_d;
  logic             lost_q, lost_d;
  logic             can_load;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    sync1_d     = bus.KEY;
    sync2_d     = sync1_q;
    key_level_d = key_level_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != key_level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) key_level_d[i] = sync2_q[i];
        else                      cnt_d[i]       = cnt_q[i] + CNT_W'(1);
      end
    end
    press_d = key_level_q & ~key_level_d;

    div_d  = div_q + DIV_W'(1);
    tick_d = (div_d == '0);

    // The core samples the slot during tick, so a tick frees it for a same-cycle event.
    slot_d   = tick_q ? SLOT_EMPTY : slot_q;
    lost_d   = lost_q & ~bus.clr_lost;
    can_load = tick_q || (slot_q == SLOT_EMPTY);
    if (press_q[0]) begin
      if (can_load) slot_d = SLOT_HIGH;
      else          lost_d = 1'b1;
      if (press_q[1]) lost_d = 1'b1;
    end else if (press_q[1]) begin
      if (can_load) slot_d = SLOT_LOW;
      else          lost_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
    if (RST) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      key_level_q <= 2'b11;
      press_q     <= 2'b00;
      div_q       <= '0;
      tick_q      <= 1'b0;
      slot_q      <= SLOT_EMPTY;
      lost_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      key_level_q <= key_level_d;
      press_q     <= press_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      slot_q      <= slot_d;
      lost_q      <= lost_d;
    end
  end

  assign bus.tick         = tick_q;
  assign bus.pressed_high = slot_q[0];
  assign bus.pressed_low  = slot_q[1];
  assign bus.key_level    = key_level_q;
  assign bus.press_lost   = lost_q;
endmodule

// File: tb/tb_key_press_latch.sv
// Randomised and directed bench for key_press_latch with a window-based reference model
// (DEBOUNCE_CYCLES=4, TICK_DIV_BIT=3, so a tick every 16 clocks).
module tb_key_press_latch;
  localparam int D      = 4;
  localparam int PERIOD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  key_press_latch_if tb_bus();

  key_press_latch #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .TICK_DIV_BIT   (3)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RST          (rst),
    .bus          (tb_bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a key level flips once the last D synchronised samples all
  // disagree with it; the tick is every 16th clock counted from reset.
  logic [1:0] raw_q  [$];
  logic [1:0] s_hist [$];
  logic [1:0] m_level;
  logic [1:0] m_fell;
  int         m_slot;   // 0 empty, 1 high, 2 low
  bit         m_lost;
  int         m_n;
  bit         m_tick;

  task automatic model_reset();
    raw_q  = {2'b11, 2'b11};
    s_hist = {};
    for (int j = 0; j < D; j++) s_hist.push_back(2'b11);
    m_level = 2'b11;
    m_fell  = 2'b00;
    m_slot  = 0;
    m_lost  = 0;
    m_n     = 0;
    m_tick  = 0;
  endtask

  task automatic model_step();
    int         ns;
    bit         nl;
    logic [1:0] s_now;
    logic [1:0] fell_now;
    ns = m_tick ? 0 : m_slot;
    nl = m_lost && !tb_bus.clr_lost;
    if (m_fell != 2'b00) begin
      if (m_fell == 2'b11) nl = 1;
      if (m_tick || m_slot == 0) ns = m_fell[0] ? 1 : 2;
      else                       nl = 1;
    end
    s_now = raw_q[0];
    raw_q.push_back(tb_bus.KEY);
    void'(raw_q.pop_front());
    s_hist.push_back(s_now);
    void'(s_hist.pop_front());
    fell_now = 2'b00;
    for (int i = 0; i < 2; i++) begin
      bit all_diff = 1;
      foreach (s_hist[j]) if (s_hist[j][i] == m_level[i]) all_diff = 0;
      if (all_diff) begin
        fell_now[i] = m_level[i];
        m_level[i]  = ~m_level[i];
      end
    end
    m_fell = fell_now;
    m_slot = ns;
    m_lost = nl;
    m_n++;
    m_tick = (m_n % PERIOD == 0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  function automatic logic [5:0] obs_vec();
    return {tb_bus.tick, tb_bus.pressed_high, tb_bus.pressed_low, tb_bus.key_level, tb_bus.press_lost};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {m_tick, m_slot == 1, m_slot == 2, m_level, m_lost};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_phase(input int ph);
    for (int c = 0; c < 2 * PERIOD && (m_n % PERIOD) != ph; c++) step();
    if ((m_n % PERIOD) != ph) begin
      $display("FAIL wait_phase: phase %0d not reached, at %0d", ph, m_n % PERIOD);
      $fatal(1);
    end
  endtask

  task automatic test_reset();
    tb_bus.KEY      = 2'b11;
    tb_bus.clr_lost = 1'b0;
    rst             = 1'b1;
    step();
    n_tests++;
    if (obs_vec() !== 6'b000110) begin
      n_fail++;
      $display("FAIL reset: dut=%b expected=%b", obs_vec(), 6'b000110);
    end
    rst = 1'b0;
  endtask

  task automatic test_press_hold();
    tb_bus.KEY = 2'b10;
    for (int i = 1; i <= 40; i++) begin
      if (i == 20) tb_bus.KEY = 2'b11;
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL press_hold cyc%0d: dut=%b model=%b", i, obs_vec(), exp_vec());
      end
      if (i == 5 || i == 6 || i == 7 || i == 16 || i == 17) begin
        logic [3:0] want;
        case (i)
          5:       want = 4'b0_0_11;   // {ph, pl, key_level}
          6:       want = 4'b0_0_10;
          7:       want = 4'b1_0_10;
          16:      want = 4'b1_0_10;
          default: want = 4'b0_0_10;
        endcase
        n_tests++;
        if ({tb_bus.pressed_high, tb_bus.pressed_low, tb_bus.key_level} !== want) begin
          n_fail++;
          $display("FAIL press_hold_timing cyc%0d: dut=%b expected=%b", i,
                   {tb_bus.pressed_high, tb_bus.pressed_low, tb_bus.key_level}, want);
        end
      end
    end
  endtask

  task automatic test_glitch();
    bit changed = 0;
    for (int i = 1; i <= 13; i++) begin
      tb_bus.KEY = (i <= 3) ? 2'b01 : 2'b11;
      step();
      if (tb_bus.key_level !== 2'b11 || tb_bus.pressed_low !== 1'b0) changed = 1;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch cyc%0d: dut=%b model=%b", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (changed || tb_bus.press_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_filtered: changed=%0d lost=%b expected 0 0", changed, tb_bus.press_lost);
    end
  endtask

  task automatic test_both();
    for (int i = 0; i < 20; i++) step();
    tb_bus.KEY = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL both cyc%0d: dut=%b model=%b", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if ({tb_bus.pressed_high, tb_bus.pressed_low, tb_bus.press_lost} !== 3'b101) begin
      n_fail++;
      $display("FAIL both_result: dut=%b expected=101",
               {tb_bus.pressed_high, tb_bus.pressed_low, tb_bus.press_lost});
    end
    tb_bus.clr_lost = 1'b1;
    step();
    tb_bus.clr_lost = 1'b0;
    n_tests++;
    if (tb_bus.press_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL both_clr_lost: dut=%b expected=0", tb_bus.press_lost);
    end
    tb_bus.KEY = 2'b11;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_drop_and_tick_load();
    wait_phase(1);
    tb_bus.KEY = 2'b10;
    step();
    step();
    tb_bus.KEY = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL drop cyc%0d: dut=%b model=%b", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if ({tb_bus.pressed_high, tb_bus.pressed_low, tb_bus.press_lost} !== 3'b101) begin
      n_fail++;
      $display("FAIL drop_result: dut=%b expected=101",
               {tb_bus.pressed_high, tb_bus.pressed_low, tb_bus.press_lost});
    end
    tb_bus.KEY      = 2'b11;
    tb_bus.clr_lost = 1'b1;
    step();
    tb_bus.clr_lost = 1'b0;
    for (int i = 0; i < 10; i++) step();
    wait_phase(1);
    tb_bus.KEY = 2'b10;
    for (int i = 0; i < 9; i++) step();
    tb_bus.KEY = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL tick_load cyc%0d: dut=%b model=%b", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if ({tb_bus.pressed_high, tb_bus.pressed_low, tb_bus.press_lost} !== 3'b010) begin
      n_fail++;
      $display("FAIL tick_load_result: dut=%b expected=010",
               {tb_bus.pressed_high, tb_bus.pressed_low, tb_bus.press_lost});
    end
    tb_bus.KEY = 2'b11;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_random();
    int cyc = 0;
    while (cyc < 600) begin
      int len = $urandom_range(1, 8);
      tb_bus.KEY = 2'($urandom_range(0, 3));
      for (int k = 0; k < len; k++) begin
        tb_bus.clr_lost = ($urandom_range(0, 9) == 0);
        step();
        cyc++;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL random cyc%0d: dut=%b model=%b", cyc, obs_vec(), exp_vec());
        end
      end
    end
    tb_bus.clr_lost = 1'b0;
    tb_bus.KEY      = 2'b11;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_reset_mid();
    wait_phase(1);
    tb_bus.KEY = 2'b01;
    for (int i = 0; i < 7; i++) step();
    tb_bus.KEY = 2'b00;
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (tb_bus.pressed_low !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_setup: pressed_low=%b expected=1", tb_bus.pressed_low);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (obs_vec() !== 6'b000110) begin
      n_fail++;
      $display("FAIL reset_mid_async: dut=%b expected=%b", obs_vec(), 6'b000110);
    end
    tb_bus.KEY = 2'b11;
    step();
    step();
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec() || (i <= PERIOD && tb_bus.tick !== (i == PERIOD))) begin
        n_fail++;
        $display("FAIL reset_resume cyc%0d: dut=%b model=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_hold_through_reset();
    int   rises = 0;
    logic prev  = 1'b0;
    rst        = 1'b1;
    tb_bus.KEY = 2'b10;
    step();
    step();
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 12) tb_bus.KEY = 2'b11;
      step();
      if (tb_bus.pressed_high === 1'b1 && prev !== 1'b1) rises++;
      prev = tb_bus.pressed_high;
      n_tests++;
      if (obs_vec() !== exp_vec() || (i <= 7 && tb_bus.pressed_high !== (i == 7))) begin
        n_fail++;
        $display("FAIL hold_reset cyc%0d: dut=%b model=%b", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL hold_reset_single: pressed_high rises=%0d expected=1", rises);
    end
  endtask

  initial begin
    tb_bus.KEY      = 2'b11;
    tb_bus.clr_lost = 1'b0;
    test_reset();
    test_press_hold();
    test_glitch();
    test_both();
    test_drop_and_tick_load();
    test_random();
    test_reset_mid();
    test_hold_through_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
